wb_commit_checker: RTL
======================

# wb_commit_checker

Synthesizable writeback-stream checker attached to the CPU's write-back stage (single-cycle or pipeline). Software loads a table of up to DEPTH expected (destination register, value) pairs. After start, the block compares the register writes that retire against that table in order. It ends in PASS or FAIL (mismatch, halt-before-complete, or timeout) and retains the failing index and data. It also counts retired instructions. This replaces ad-hoc bench asserts with a reusable, parametrised result checker usable in simulation and on FPGA.

## Interface
Parameters:
- WORD, 64, data width of writeback value
- INST_SIZE, 32, instruction width
- DEPTH, 8, max expected entries (power of 2, ≥2)
- HALT_INST, 32'h1400_0000, encoding treated as program end (B #0)
- TO_W, 32, timeout counter width

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- cfg_we  in  1  write one table entry
- cfg_addr  in  $clog2(DEPTH)  table index
- cfg_reg  in  5  expected destination register
- cfg_data  in  WORD  expected value
- cfg_num  in  $clog2(DEPTH)+1  entries to check, sampled at start
- cfg_timeout  in  TO_W  cycle budget, sampled at start; 0 = no timeout
- start  in  1  begin check (pulse)
- wb_valid  in  1  an instruction retires this cycle
- wb_we  in  1  retiring instruction writes a register
- wb_inst  in  INST_SIZE  retiring instruction
- wb_reg  in  5  destination register
- wb_data  in  WORD  writeback value
- busy  out  1  in RUN
- done  out  1  sticky, result valid
- pass  out  1  valid when done
- reason  out  2  0 none, 1 mismatch, 2 halt early, 3 timeout
- fail_idx  out  $clog2(DEPTH)  entry index at failure
- fail_data  out  WORD  wb_data captured at mismatch
- retire_cnt  out  32  retired instructions since start, saturating

## Operation
- FSM: IDLE → RUN on start; RUN → DONE on pass/fail; DONE → RUN on start. The table is not cleared.
- cfg_we is honoured only outside RUN. start in RUN is ignored.
- At start: idx←0, retire_cnt←0, tcnt←0, done←0, pass←0, reason←0. Latch cfg_num and cfg_timeout.
- If cfg_num==0 at start, go to DONE with pass=1 on the next edge.
- RUN, per cycle with wb_valid:
  - Increment retire_cnt; saturate at 2^32-1.
  - If wb_we and wb_reg≠31 and wb_reg==table[idx].reg:
    - If data equal: idx+1. When idx+1==cfg_num, set PASS.
    - If data differ: FAIL, reason 1, fail_idx=idx, fail_data=wb_data.
  - Writes to other registers, or to X31, are ignored.
- If wb_inst==HALT_INST with wb_valid and the table is not complete: FAIL reason 2, fail_idx=idx.
- tcnt increments every RUN cycle. If cfg_timeout≠0 and tcnt+1==cfg_timeout with no completion this cycle: FAIL reason 3.
- Same-cycle priority: mismatch > final match (PASS) > halt > timeout.
- Reset anywhere: IDLE, and all outputs 0. The table contents after reset are undefined and must be reloaded.

## Timing
- Reset values: busy, done, pass, reason, fail_idx, fail_data, retire_cnt all 0.
- All outputs are registered.
- Verdict latency: the deciding wb beat at edge N gives done=1 after edge N+1. busy falls on the same edge.
- start at edge S: busy=1 after S. The first beat compared is the one present at edge S+1.
- Table write: cfg_we at edge W is visible to a start at edge W+1.
- done, pass, reason, fail_* and retire_cnt hold until the next start.

## Test plan
- Load {9:1, 9:2, 9:0x27, 9:0x45, 9:0x99}, cfg_num=5. Drive the matching writes interleaved with X10 writes -> done=1, pass=1, retire_cnt equals beats driven.
- Same table, third write 9:0x28 -> pass=0, reason=1, fail_idx=2, fail_data=0x28, done one cycle after that beat.
- cfg_num=1, entry {0:0x21C3677C82B40000}. Retire HALT_INST before the match -> reason=2, fail_idx=0.
- cfg_timeout=20, no matching writes -> done after 20 RUN cycles, reason=3. Repeat with the final match on cycle 20 -> pass=1.
- Final match and HALT_INST in the same beat -> pass=1. cfg_num=0 -> pass=1 one cycle after start. start while busy -> ignored.
- Assert rst_n mid-RUN, asynchronously between edges -> all outputs 0 immediately. Reload, then start -> normal pass.

Source files
------------

// File: rtl/wb_commit_checker.sv
// Write-back commit checker: compares retiring register writes against a
// software-loaded table of expected (register, value) pairs, in order.
module wb_commit_checker #(
   parameter int unsigned          WORD      = 64,
   parameter int unsigned          INST_SIZE = 32,
   parameter int unsigned          DEPTH     = 8,
   parameter logic [INST_SIZE-1:0] HALT_INST = 32'h1400_0000,
   parameter int unsigned          TO_W      = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       cfg_we,
   input  logic [$clog2(DEPTH)-1:0]   cfg_addr,
   input  logic [4:0]                 cfg_reg,
   input  logic [WORD-1:0]            cfg_data,
   input  logic [$clog2(DEPTH):0]     cfg_num,
   input  logic [TO_W-1:0]            cfg_timeout,
   input  logic                       start,
   input  logic                       wb_valid,
   input  logic                       wb_we,
   input  logic [INST_SIZE-1:0]       wb_inst,
   input  logic [4:0]                 wb_reg,
   input  logic [WORD-1:0]            wb_data,
   output logic                       busy,
   output logic                       done,
   output logic                       pass,
   output logic [1:0]                 reason,
   output logic [$clog2(DEPTH)-1:0]   fail_idx,
   output logic [WORD-1:0]            fail_data,
   output logic [31:0]                retire_cnt
);

   localparam int unsigned IW = $clog2(DEPTH);
   localparam int unsigned NW = IW + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_e;

   typedef enum logic [1:0] {
      R_NONE     = 2'd0,
      R_MISMATCH = 2'd1,
      R_HALT     = 2'd2,
      R_TIMEOUT  = 2'd3
   } reason_e;

   logic [4:0]      tbl_reg_q  [DEPTH];
   logic [WORD-1:0] tbl_data_q [DEPTH];

   state_e          state_q;
   logic            pend_q;
   logic [IW-1:0]   idx_q;
   logic [NW-1:0]   num_q;
   logic [TO_W-1:0] timeout_q;
   logic [TO_W-1:0] tcnt_q;
   logic            busy_q;
   logic            done_q;
   logic            pass_q;
   reason_e         reason_q;
   logic [IW-1:0]   fail_idx_q;
   logic [WORD-1:0] fail_data_q;
   logic [31:0]     retire_cnt_q;

   logic active_d, beat_d, hit_d, mism_d, last_d, halt_d, tmo_d;

   // NOTE: the table is plain storage with no reset; software reloads it
   // after reset, and leaving it unreset lets it map onto RAM.
   always_ff @(posedge clk) begin
      if (cfg_we && state_q != S_RUN) begin
         tbl_reg_q[cfg_addr]  <= cfg_reg;
         tbl_data_q[cfg_addr] <= cfg_data;
      end
   end

   // Once a verdict is pending the remaining RUN cycle makes no decisions.
   always_comb begin
      active_d = (state_q == S_RUN) && !pend_q;
      beat_d   = active_d && wb_valid;
      hit_d    = beat_d && wb_we && (wb_reg != 5'd31) && (wb_reg == tbl_reg_q[idx_q]);
      mism_d   = hit_d && (wb_data != tbl_data_q[idx_q]);
      last_d   = hit_d && !mism_d && (({1'b0, idx_q} + 1'b1) == num_q);
      halt_d   = beat_d && (wb_inst == HALT_INST);
      tmo_d    = active_d && (timeout_q != '0) && ((tcnt_q + 1'b1) == timeout_q);
   end

   // The verdict is captured on the deciding edge; done/busy follow one edge later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         pend_q       <= 1'b0;
         idx_q        <= '0;
         num_q        <= '0;
         timeout_q    <= '0;
         tcnt_q       <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         reason_q     <= R_NONE;
         fail_idx_q   <= '0;
         fail_data_q  <= '0;
         retire_cnt_q <= '0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state_q      <= S_RUN;
                  busy_q       <= 1'b1;
                  done_q       <= 1'b0;
                  pass_q       <= (cfg_num == '0);
                  pend_q       <= (cfg_num == '0);
                  reason_q     <= R_NONE;
                  fail_idx_q   <= '0;
                  fail_data_q  <= '0;
                  retire_cnt_q <= '0;
                  idx_q        <= '0;
                  tcnt_q       <= '0;
                  num_q        <= cfg_num;
                  timeout_q    <= cfg_timeout;
               end
            end
            S_RUN: begin
               if (pend_q) begin
                  state_q <= S_DONE;
                  pend_q  <= 1'b0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  tcnt_q <= tcnt_q + 1'b1;
                  if (wb_valid && retire_cnt_q != 32'hFFFF_FFFF) begin
                     retire_cnt_q <= retire_cnt_q + 32'd1;
                  end
                  if (mism_d) begin
                     pend_q      <= 1'b1;
                     reason_q    <= R_MISMATCH;
                     fail_idx_q  <= idx_q;
                     fail_data_q <= wb_data;
                  end else if (last_d) begin
                     pend_q <= 1'b1;
                     pass_q <= 1'b1;
                  end else if (halt_d) begin
                     pend_q     <= 1'b1;
                     reason_q   <= R_HALT;
                     fail_idx_q <= idx_q;
                  end else if (tmo_d) begin
                     pend_q     <= 1'b1;
                     reason_q   <= R_TIMEOUT;
                     fail_idx_q <= idx_q;
                  end else if (hit_d) begin
                     idx_q <= idx_q + 1'b1;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign reason     = reason_q;
   assign fail_idx   = fail_idx_q;
   assign fail_data  = fail_data_q;
   assign retire_cnt = retire_cnt_q;

endmodule
